// File: rtl/sseg_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_mux_pkg
// Purpose  : Shared constants and helpers for the multiplexed seven-segment
//            display driver (blank segment code, slot-index width helper,
//            active-low one-hot anode encoder).
// Revision : 1.0 - initial release
// ============================================================================
package sseg_mux_pkg;

    // All segments off (segments are active-low)
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Widest anode vector the helper below can produce
    localparam int         MAX_DIGITS = 8;

    // Width of a slot index for a display of n digits (DIG_W)
    function automatic int dig_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Active-low anode vector for a slot: digit i drives an[num_digits-1-i].
    // Bits at and above num_digits stay high and are sliced off by the caller.
    function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input int num_digits,
                                                            input int slot);
        logic [MAX_DIGITS-1:0] vec;
        vec = '1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i == num_digits - 1 - slot) begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

endpackage : sseg_mux_pkg
`default_nettype wire

// File: rtl/sseg_mux_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : sseg_mux_prescaler
// Purpose  : Slot timebase for the display scanner. A prescale counter runs
//            0..PRESCALE-1; at its wrap the slot index advances through
//            0..NUM_DIGITS-1.
// Ports    : clk, reset (async, active-high)
//            cnt       - position inside the current slot
//            slot      - digit currently being scanned
//            slot_tick - registered pulse, high for the cycle after each wrap
//            frame_end - combinational, high on the last cycle of a frame
// Revision : 1.0 - initial release
// ============================================================================
module sseg_mux_prescaler
    import sseg_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
    parameter int DIG_W      = dig_w(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic [DIG_W-1:0] slot,
    output logic             slot_tick,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] C_SLOT_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [DIG_W-1:0] r_slot;
    logic             r_slot_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_slot      <= '0;
            r_slot_tick <= 1'b0;
        end else begin
            r_slot_tick <= w_wrap;
            if (w_wrap) begin
                r_cnt  <= '0;
                r_slot <= (r_slot == C_SLOT_LAST) ? '0 : r_slot + 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt       = r_cnt;
    assign slot      = r_slot;
    assign slot_tick = r_slot_tick;
    assign frame_end = w_wrap && (r_slot == C_SLOT_LAST);

endmodule : sseg_mux_prescaler
`default_nettype wire

// File: rtl/sseg_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : sseg_mux_scan
// Purpose  : Time-multiplexed common-anode seven-segment driver. Digit data
//            is captured into shadow registers once per frame so a scan never
//            mixes two values. Adds per-digit enable and decimal point, PWM
//            brightness (read live) and a dead-time at the start of each slot.
// Ports    : clk, reset (async, active-high)
//            digits_in  - 7 active-low segment bits per digit
//            dp_mask    - decimal point per digit (1 = lit)
//            digit_en   - per-digit display enable
//            brightness - PWM duty, lit while pwm <= brightness
//            blink_mask - per-digit blink (SSEG_MUX_BLINK_EN builds only)
//            an         - active-low anodes, digit i on an[NUM_DIGITS-1-i]
//            sseg, dp   - active-low segments / decimal point
//            slot_tick  - one-cycle pulse at each slot advance
// Macro    : SSEG_MUX_BLINK_EN - adds blink_mask, BLINK_HALF and blink phase.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_mux_scan
    import sseg_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int DEAD_CYC   = 2,
    parameter int DUTY_W     = 4
`ifdef SSEG_MUX_BLINK_EN
    ,
    parameter int BLINK_HALF = 50
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [DUTY_W-1:0]       brightness,
`ifdef SSEG_MUX_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic                    slot_tick
);

    localparam int C_CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int C_DIG_W = dig_w(NUM_DIGITS);

    // ---------------------------------------------------------------- checks
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
        $error("sseg_mux_scan: NUM_DIGITS must be 2..8");
    end
    if (PRESCALE < 2 || PRESCALE <= DEAD_CYC) begin : g_bad_prescale
        $error("sseg_mux_scan: PRESCALE must be >= 2 and > DEAD_CYC");
    end
    if (DEAD_CYC < 0 || DUTY_W < 1) begin : g_bad_misc
        $error("sseg_mux_scan: DEAD_CYC must be >= 0 and DUTY_W >= 1");
    end

    // -------------------------------------------------------------- timebase
    logic [C_CNT_W-1:0] w_cnt;
    logic [C_DIG_W-1:0] w_slot;
    logic               w_frame_end;

    sseg_mux_prescaler #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .CNT_W      (C_CNT_W),
        .DIG_W      (C_DIG_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .cnt        (w_cnt),
        .slot       (w_slot),
        .slot_tick  (slot_tick),
        .frame_end  (w_frame_end)
    );

    // ------------------------------------------------------ shadow registers
    logic [7*NUM_DIGITS-1:0] r_digits_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [NUM_DIGITS-1:0]   r_en_sh;
    logic                    r_load_pending;
    logic                    w_load;

    // The first edge after reset loads immediately so frame 0 is not blank.
    assign w_load = r_load_pending | w_frame_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits_sh    <= {NUM_DIGITS{SEG_BLANK}};
            r_dp_sh        <= '0;
            r_en_sh        <= '0;
            r_load_pending <= 1'b1;
        end else begin
            r_load_pending <= 1'b0;
            if (w_load) begin
                r_digits_sh <= digits_in;
                r_dp_sh     <= dp_mask;
                r_en_sh     <= digit_en;
            end
        end
    end

    // ------------------------------------------------------------------ blink
    logic w_blink_off;

`ifdef SSEG_MUX_BLINK_EN
    localparam int C_BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    if (BLINK_HALF < 1) begin : g_bad_blink_half
        $error("sseg_mux_scan: BLINK_HALF must be >= 1");
    end

    logic [NUM_DIGITS-1:0] r_blink_sh;
    logic [C_BLK_W-1:0]    r_frame_cnt;
    logic                  r_blink_phase;
    logic                  w_blink_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_sh    <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_load) begin
                r_blink_sh <= blink_mask;
            end
            // Only real frame ends count; the post-reset load is not a frame.
            if (w_frame_end) begin
                if (r_frame_cnt == C_BLK_W'(BLINK_HALF - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_blink_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_slot == C_DIG_W'(i)) begin
                w_blink_bit = r_blink_sh[i];
            end
        end
    end

    assign w_blink_off = r_blink_phase & w_blink_bit;
`else
    assign w_blink_off = 1'b0;
`endif

    // ------------------------------------------------------------ pwm / lit
    logic [DUTY_W-1:0] r_pwm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    logic [6:0]              w_code;
    logic                    w_en_bit;
    logic                    w_dp_bit;
    logic                    w_lit;
    logic [MAX_DIGITS-1:0]   w_an_full;

    always_comb begin
        w_code   = SEG_BLANK;
        w_en_bit = 1'b0;
        w_dp_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_slot == C_DIG_W'(i)) begin
                w_code   = r_digits_sh[7*i +: 7];
                w_en_bit = r_en_sh[i];
                w_dp_bit = r_dp_sh[i];
            end
        end
    end

    assign w_an_full = an_onehot_low(NUM_DIGITS, int'(w_slot));
    assign w_lit     = w_en_bit
                     && (int'(w_cnt) >= DEAD_CYC)
                     && (r_pwm <= brightness)
                     && !w_blink_off;

    // ---------------------------------------------------------- output regs
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_sseg;
    logic                  r_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an   <= '1;
            r_sseg <= SEG_BLANK;
            r_dp   <= 1'b1;
        end else if (w_lit) begin
            r_an   <= w_an_full[NUM_DIGITS-1:0];
            r_sseg <= w_code;
            r_dp   <= ~w_dp_bit;
        end else begin
            r_an   <= '1;
            r_sseg <= SEG_BLANK;
            r_dp   <= 1'b1;
        end
    end

    assign an   = r_an;
    assign sseg = r_sseg;
    assign dp   = r_dp;

endmodule : sseg_mux_scan
`default_nettype wire

// File: tb/tb_sseg_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_mux_scan
// Purpose  : Self-checking bench for sseg_mux_scan (NUM_DIGITS=4, PRESCALE=8,
//            DEAD_CYC=2, DUTY_W=2). Frame-level vectors are applied from a
//            table, each starting from reset so frame 0 shows them; corner
//            cases (tear-free update, mid-frame reset, blink) are hand-written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_mux_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [27:0] digits_in = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit_en = '0;
    logic [1:0]  brightness = '0;
`ifdef SSEG_MUX_BLINK_EN
    logic [3:0]  blink_mask = '0;
`endif
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        slot_tick;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [27:0] C_STD_DIGITS = {7'h40, 7'h79, 7'h24, 7'h30};

    sseg_mux_scan #(
        .NUM_DIGITS (4),
        .PRESCALE   (8),
        .DEAD_CYC   (2),
        .DUTY_W     (2)
`ifdef SSEG_MUX_BLINK_EN
        ,
        .BLINK_HALF (2)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .brightness (brightness),
`ifdef SSEG_MUX_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .slot_tick  (slot_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] digits;
        logic [3:0]  dpm;
        logic [3:0]  en;
        logic [1:0]  bright;
        logic [7:0]  lit_pos;   // bit p set: lit at slot position p
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp,
                         input logic e_tick);
        n_checks++;
        if (an !== e_an || sseg !== e_seg || dp !== e_dp || slot_tick !== e_tick) begin
            n_fail++;
            $display("FAIL %s: got an=%b sseg=%h dp=%b tick=%b, expected an=%b sseg=%h dp=%b tick=%b",
                     name, an, sseg, dp, slot_tick, e_an, e_seg, e_dp, e_tick);
        end
    endtask

    // Holds reset for two edges, checks the idle pins, releases at a negedge.
    // The next posedge is cycle k=1 (slot 0, position 0).
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        check("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic       lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;

        vecs[0] = '{C_STD_DIGITS, 4'b0000, 4'b1111, 2'd3, 8'b1111_1100};
        vecs[1] = '{C_STD_DIGITS, 4'b0010, 4'b1111, 2'd0, 8'b0001_0000};
        vecs[2] = '{C_STD_DIGITS, 4'b0000, 4'b0101, 2'd3, 8'b1111_1100};
        vecs[3] = '{{7'h00, 7'h06, 7'h5B, 7'h4F}, 4'b1001, 4'b1010, 2'd1, 8'b0011_0000};

        // ------------------------------------------------ table-driven frames
        for (int v = 0; v < 4; v++) begin
            digits_in  = vecs[v].digits;
            dp_mask    = vecs[v].dpm;
            digit_en   = vecs[v].en;
            brightness = vecs[v].bright;
            do_reset();
            for (int k = 1; k <= 32; k++) begin
                int s;
                int p;
                step();
                s     = (k - 1) / 8;
                p     = (k - 1) % 8;
                lit   = vecs[v].en[s] && vecs[v].lit_pos[p];
                e_an  = lit ? ~(4'b1000 >> s) : 4'hF;
                e_seg = lit ? vecs[v].digits[7*s +: 7] : 7'h7F;
                e_dp  = lit ? ~vecs[v].dpm[s] : 1'b1;
                check($sformatf("vec%0d_k%0d", v, k), e_an, e_seg, e_dp, (p == 7));
            end
        end

        // ------------------------------------------------ tear-free update
        digits_in  = C_STD_DIGITS;
        dp_mask    = 4'b0000;
        digit_en   = 4'b1111;
        brightness = 2'd3;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k == 4)  check("tear_f0_slot0", 4'b0111, 7'h30, 1'b1, 1'b0);
            if (k == 18) digits_in[6:0] = 7'h12;  // slot 2 of frame 0
            if (k == 28) check("tear_f0_slot3", 4'b1110, 7'h40, 1'b1, 1'b0);
            if (k == 36) check("tear_f1_slot0", 4'b0111, 7'h12, 1'b1, 1'b0);
        end

        // ------------------------------------------------ mid-frame reset
        digits_in = C_STD_DIGITS;
        do_reset();
        for (int k = 1; k <= 20; k++) step();
        check("pre_reset_slot2", 4'b1101, 7'h79, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        check("reset_next_cycle", 4'hF, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) check("restart_dead", 4'hF, 7'h7F, 1'b1, 1'b0);
            if (k == 4) check("restart_slot0", 4'b0111, 7'h30, 1'b1, 1'b0);
            if (k == 8) check("restart_tick", 4'b0111, 7'h30, 1'b1, 1'b1);
        end

`ifdef SSEG_MUX_BLINK_EN
        // ------------------------------------------------ blink
        blink_mask = 4'b0001;
        do_reset();
        for (int k = 1; k <= 5 * 32; k++) begin
            int f;
            step();
            f = (k - 1) / 32;
            if ((k - 1) % 32 == 3) begin
                if (f == 2 || f == 3)
                    check($sformatf("blink_dark_f%0d", f), 4'hF, 7'h7F, 1'b1, 1'b0);
                else
                    check($sformatf("blink_lit_f%0d", f), 4'b0111, 7'h30, 1'b1, 1'b0);
            end
            if ((k - 1) % 32 == 11)
                check($sformatf("blink_other_f%0d", f), 4'b1011, 7'h24, 1'b1, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sseg_mux_scan
`default_nettype wire
